// File: rtl/gui_pkg.sv
// Shared GUI definitions: pixel colours and the hold/auto-repeat state encodings.
package gui_pkg;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

endpackage

// File: rtl/hold_repeat.sv
// Joystick direction decoder with press-then-hold auto-repeat; emits one-cycle move pulses.
module hold_repeat
  import gui_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 6_250_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic up,
  input  logic down,
  output logic move_up,
  output logic move_down
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  repeat_state_e    state_r, state_s;
  dir_e             dir_r, dir_nxt_s, dir_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             move_s;

  // Both directions pressed together cancel out.
  always_comb begin
    if (up && !down) begin
      dir_s = DIR_UP;
    end else if (down && !up) begin
      dir_s = DIR_DOWN;
    end else begin
      dir_s = DIR_NONE;
    end
  end

  // Next-state logic; a change of direction restarts the initial delay.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    dir_nxt_s = dir_r;
    move_s    = 1'b0;
    if (!enable) begin
      state_s   = IDLE;
      cnt_s     = CNT_ZERO;
      dir_nxt_s = DIR_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (dir_s != DIR_NONE) begin
            move_s    = 1'b1;
            cnt_s     = DELAY_LOAD;
            state_s   = DELAY;
            dir_nxt_s = dir_s;
          end else begin
            cnt_s = CNT_ZERO;
          end
        end
        DELAY, REPEAT: begin
          if (dir_s == DIR_NONE) begin
            state_s   = IDLE;
            cnt_s     = CNT_ZERO;
            dir_nxt_s = DIR_NONE;
          end else if (dir_s != dir_r) begin
            move_s    = 1'b1;
            cnt_s     = DELAY_LOAD;
            state_s   = DELAY;
            dir_nxt_s = dir_s;
          end else if (cnt_r == CNT_ZERO) begin
            move_s  = 1'b1;
            cnt_s   = PERIOD_LOAD;
            state_s = REPEAT;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_s   = IDLE;
          cnt_s     = CNT_ZERO;
          dir_nxt_s = DIR_NONE;
        end
      endcase
    end
  end

  // State, counter and last-direction registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      dir_r   <= DIR_NONE;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      dir_r   <= dir_nxt_s;
    end
  end

  assign move_up   = move_s && (dir_s == DIR_UP);
  assign move_down = move_s && (dir_s == DIR_DOWN);

endmodule

// File: rtl/menu_selector.sv
// Menu navigation: selected index with saturate/wrap moves, confirm pulse, and option-box pixel decoding.
module menu_selector
  import gui_pkg::*;
#(
  parameter int NUM_OPTIONS   = 2,
  parameter int DEFAULT_INDEX = 0,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 6_250_000,
  parameter int ITEM_COL0     = 260,
  parameter int ITEM_ROW0     = 180,
  parameter int ITEM_W        = 120,
  parameter int ITEM_H        = 24,
  parameter int IDX_W         = $clog2(NUM_OPTIONS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [9:0]       row,
  input  logic [9:0]       col,
  input  logic             control_up,
  input  logic             control_down,
  input  logic             control_select,
  output logic [2:0]       rgb,
  output logic [IDX_W-1:0] selected_index,
  output logic             confirm_valid,
  output logic [IDX_W-1:0] confirm_index
);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPTIONS - 1);
  localparam logic [IDX_W-1:0] IDX_DEF  = IDX_W'(DEFAULT_INDEX);

  logic [IDX_W-1:0]       selected_index_r, idx_s;
  logic [IDX_W-1:0]       confirm_index_r;
  logic                   confirm_valid_r;
  logic                   select_prev_r;
  logic                   select_rise_s;
  logic                   move_up_s, move_down_s;
  logic [NUM_OPTIONS-1:0] hit_s, border_s;
  logic                   sel_hit_s;
  logic [2:0]             rgb_s;

  hold_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .up        (control_up),
    .down      (control_down),
    .move_up   (move_up_s),
    .move_down (move_down_s)
  );

  // Up walks toward index 0; ends compare against the real last index, not 2^IDX_W-1.
  always_comb begin
    idx_s = selected_index_r;
    if (move_up_s) begin
      if (selected_index_r == IDX_ZERO) begin
        idx_s = (WRAP != 0) ? IDX_LAST : IDX_ZERO;
      end else begin
        idx_s = selected_index_r - IDX_ONE;
      end
    end else if (move_down_s) begin
      if (selected_index_r == IDX_LAST) begin
        idx_s = (WRAP != 0) ? IDX_ZERO : IDX_LAST;
      end else begin
        idx_s = selected_index_r + IDX_ONE;
      end
    end else begin
      idx_s = selected_index_r;
    end
  end

  assign select_rise_s = control_select && !select_prev_r;

  // Index and confirm registers; the confirmed value is the pre-move index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      selected_index_r <= IDX_DEF;
      confirm_valid_r  <= 1'b0;
      confirm_index_r  <= IDX_ZERO;
      select_prev_r    <= 1'b0;
    end else if (!enable) begin
      selected_index_r <= IDX_DEF;
      confirm_valid_r  <= 1'b0;
      confirm_index_r  <= IDX_ZERO;
      select_prev_r    <= 1'b0;
    end else begin
      selected_index_r <= idx_s;
      confirm_valid_r  <= select_rise_s;
      select_prev_r    <= control_select;
      if (select_rise_s) begin
        confirm_index_r <= selected_index_r;
      end
    end
  end

  // Per-box hit and border flags; boxes are stacked vertically and never overlap.
  always_comb begin
    hit_s     = {NUM_OPTIONS{1'b0}};
    border_s  = {NUM_OPTIONS{1'b0}};
    sel_hit_s = 1'b0;
    for (int k = 0; k < NUM_OPTIONS; k++) begin
      hit_s[k] = (int'(col) >= ITEM_COL0) && (int'(col) < ITEM_COL0 + ITEM_W) &&
                 (int'(row) >= ITEM_ROW0 + k * ITEM_H) &&
                 (int'(row) < ITEM_ROW0 + (k + 1) * ITEM_H);
      border_s[k] = (int'(col) == ITEM_COL0) || (int'(col) == ITEM_COL0 + ITEM_W - 1) ||
                    (int'(row) == ITEM_ROW0 + k * ITEM_H) ||
                    (int'(row) == ITEM_ROW0 + (k + 1) * ITEM_H - 1);
      sel_hit_s = sel_hit_s || (hit_s[k] && (IDX_W'(k) == selected_index_r));
    end
  end

  // Colour priority: selected box fill, then other box outlines, else black.
  always_comb begin
    rgb_s = COLOR_BLACK;
    if (sel_hit_s) begin
      rgb_s = COLOR_WHITE;
    end else if (|(hit_s & border_s)) begin
      rgb_s = COLOR_GREEN;
    end else begin
      rgb_s = COLOR_BLACK;
    end
  end

  assign rgb            = rgb_s;
  assign selected_index = selected_index_r;
  assign confirm_valid  = confirm_valid_r;
  assign confirm_index  = confirm_index_r;

endmodule

// File: tb/tb_menu_selector.sv
// Self-checking bench for menu_selector: saturate/wrap moves, hold auto-repeat, confirm and pixels.
module tb_menu_selector;
  import gui_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [9:0] row = 10'd0;
  logic [9:0] col = 10'd0;
  logic       control_up = 1'b0;
  logic       control_down = 1'b0;
  logic       control_select = 1'b0;

  logic [2:0] rgb_a, rgb_b, rgb_c;
  logic [1:0] idx_a, idx_b, cidx_a, cidx_b;
  logic [2:0] idx_c, cidx_c;
  logic       cv_a, cv_b, cv_c;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  menu_selector #(.NUM_OPTIONS(3), .WRAP(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .row(row), .col(col),
    .control_up(control_up), .control_down(control_down), .control_select(control_select),
    .rgb(rgb_a), .selected_index(idx_a), .confirm_valid(cv_a), .confirm_index(cidx_a));

  menu_selector #(.NUM_OPTIONS(3), .WRAP(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .row(row), .col(col),
    .control_up(control_up), .control_down(control_down), .control_select(control_select),
    .rgb(rgb_b), .selected_index(idx_b), .confirm_valid(cv_b), .confirm_index(cidx_b));

  menu_selector #(.NUM_OPTIONS(8), .WRAP(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .row(row), .col(col),
    .control_up(control_up), .control_down(control_down), .control_select(control_select),
    .rgb(rgb_c), .selected_index(idx_c), .confirm_valid(cv_c), .confirm_index(cidx_c));

  task automatic do_reset();
    @(negedge clock);
    control_up = 1'b0; control_down = 1'b0; control_select = 1'b0; enable = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // One-cycle press followed by one idle cycle so the repeat FSM returns to IDLE.
  task automatic pulse(input logic u, input logic d);
    control_up = u; control_down = d;
    @(negedge clock);
    control_up = 1'b0; control_down = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (idx_a !== 2'd0 || idx_b !== 2'd0 || idx_c !== 3'd0) begin
      errors++; $display("FAIL reset_index: got a=%0d b=%0d c=%0d want 0", idx_a, idx_b, idx_c);
    end
    checks++;
    if (cv_a !== 1'b0 || cv_b !== 1'b0 || cv_c !== 1'b0 ||
        cidx_a !== 2'd0 || cidx_b !== 2'd0 || cidx_c !== 3'd0) begin
      errors++; $display("FAIL reset_confirm: got valid=%b%b%b idx=%0d/%0d/%0d want 0",
                         cv_a, cv_b, cv_c, cidx_a, cidx_b, cidx_c);
    end
  endtask

  task automatic test_saturate();
    int ea, eb;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back((i < 2) ? i + 1 : 2);
      exp_q.push_back((i < 2) ? i + 1 : 0);
      pulse(1'b0, 1'b1);
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      checks++;
      if (int'(idx_a) !== ea) begin
        errors++; $display("FAIL saturate_down[%0d]: got %0d want %0d", i, idx_a, ea);
      end
      checks++;
      if (int'(idx_b) !== eb) begin
        errors++; $display("FAIL wrap_down[%0d]: got %0d want %0d", i, idx_b, eb);
      end
    end
  endtask

  task automatic test_wrap();
    int ea, eb;
    do_reset();
    exp_q.push_back(0); exp_q.push_back(2);
    pulse(1'b1, 1'b0);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    checks++;
    if (int'(idx_a) !== ea || int'(idx_b) !== eb) begin
      errors++; $display("FAIL up_at_zero: got a=%0d b=%0d want a=%0d b=%0d", idx_a, idx_b, ea, eb);
    end
    exp_q.push_back(1); exp_q.push_back(0);
    pulse(1'b0, 1'b1);
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    checks++;
    if (int'(idx_a) !== ea || int'(idx_b) !== eb) begin
      errors++; $display("FAIL down_wrap: got a=%0d b=%0d want a=%0d b=%0d", idx_a, idx_b, ea, eb);
    end
  endtask

  task automatic test_hold_repeat();
    int model, e;
    do_reset();
    model = 0;
    control_down = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if ((i == 1 || (i >= 11 && (i - 11) % 4 == 0)) && model < 7) model++;
      exp_q.push_back(model);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (int'(idx_c) !== e) begin
        errors++; $display("FAIL hold_cycle%0d: got %0d want %0d", i, idx_c, e);
      end
    end
    control_down = 1'b0;
    @(negedge clock);
    checks++;
    if (idx_c !== 3'd6) begin
      errors++; $display("FAIL hold_final: got %0d want 6", idx_c);
    end
  endtask

  task automatic test_both_pressed();
    do_reset();
    pulse(1'b0, 1'b1);
    control_up = 1'b1; control_down = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (idx_c !== 3'd1 || dut_c.u_repeat.state_r !== IDLE) begin
        errors++; $display("FAIL both_pressed[%0d]: got idx=%0d state=%0d want idx=1 state=IDLE",
                           i, idx_c, dut_c.u_repeat.state_r);
      end
    end
    control_up = 1'b0; control_down = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_confirm();
    int pulses;
    do_reset();
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulses = 0;
    control_select = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (cv_c === 1'b1) pulses++;
      if (i == 0) begin
        checks++;
        if (cv_c !== 1'b1 || cidx_c !== 3'd2) begin
          errors++; $display("FAIL confirm_first: got valid=%b idx=%0d want valid=1 idx=2", cv_c, cidx_c);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL confirm_count: got %0d pulses want 1", pulses);
    end
    control_select = 1'b0;
    @(negedge clock);
    control_select = 1'b1; control_up = 1'b1;
    @(negedge clock);
    control_up = 1'b0;
    checks++;
    if (cv_c !== 1'b1 || cidx_c !== 3'd2 || idx_c !== 3'd1) begin
      errors++; $display("FAIL confirm_with_move: got valid=%b cidx=%0d idx=%0d want 1/2/1", cv_c, cidx_c, idx_c);
    end
    control_select = 1'b0;
    @(negedge clock);
    enable = 1'b0; control_select = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (idx_c !== 3'd0 || cv_c !== 1'b0 || cidx_c !== 3'd0) begin
        errors++; $display("FAIL disable[%0d]: got idx=%0d valid=%b cidx=%0d want 0/0/0", i, idx_c, cv_c, cidx_c);
      end
    end
    control_select = 1'b0;
    enable = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_pixel();
    do_reset();
    pulse(1'b0, 1'b1);
    row = 10'd209; col = 10'd265;
    #1;
    checks++;
    if (rgb_c !== 3'b111) begin
      errors++; $display("FAIL pixel_selected: got %b want 111", rgb_c);
    end
    do_reset();
    row = 10'd209; col = 10'd265;
    #1;
    checks++;
    if (rgb_c !== 3'b000) begin
      errors++; $display("FAIL pixel_interior: got %b want 000", rgb_c);
    end
    col = 10'd260;
    #1;
    checks++;
    if (rgb_c !== 3'b010) begin
      errors++; $display("FAIL pixel_border: got %b want 010", rgb_c);
    end
    row = 10'd100; col = 10'd300;
    #1;
    checks++;
    if (rgb_c !== 3'b000) begin
      errors++; $display("FAIL pixel_outside: got %b want 000", rgb_c);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    control_down = 1'b1;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (idx_c !== 3'd0 || dut_c.u_repeat.state_r !== IDLE) begin
      errors++; $display("FAIL async_reset: got idx=%0d state=%0d want 0/IDLE", idx_c, dut_c.u_repeat.state_r);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (idx_c !== 3'd1) begin
      errors++; $display("FAIL fresh_press_after_reset: got %0d want 1", idx_c);
    end
    control_down = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_wrap();
    test_hold_repeat();
    test_both_pressed();
    test_confirm();
    test_pixel();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/menu_selector.md
Name: menu_selector

Overview:
Parametrised menu-navigation block for the Pong GUI. It generalises the two-option pause-menu selector to NUM_OPTIONS entries. It adds optional wrap-around, edge-detected moves with hold-to-auto-repeat, a confirm handshake, and per-option highlight drawing for the VGA pixel pipeline. Start, pause and settings menus instantiate it and consume selected_index and confirm_valid.

Parameters:
NUM_OPTIONS, 2, number of menu entries (2..16)
DEFAULT_INDEX, 0, index loaded on reset and whenever enable is low
WRAP, 0, 1 = up from 0 goes to NUM_OPTIONS-1 and down from last goes to 0; 0 = saturate at the ends
REPEAT_DELAY, 25_000_000, clock cycles a direction must be held before the first auto-repeat
REPEAT_PERIOD, 6_250_000, clock cycles between later auto-repeats
ITEM_COL0, 260, left column of the option boxes
ITEM_ROW0, 180, top row of option 0
ITEM_W, 120, box width in pixels
ITEM_H, 24, box height; option k occupies rows ITEM_ROW0+k*ITEM_H .. +ITEM_H-1
IDX_W, $clog2(NUM_OPTIONS), derived width of the index; not to be overridden

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  menu is active; low holds the block idle
row  input  10  pixel row being queried
col  input  10  pixel column being queried
control_up  input  1  joystick up (level)
control_down  input  1  joystick down (level)
control_select  input  1  joystick confirm (level)
rgb  output  3  pixel colour for (row,col); 3'b000 outside all boxes
selected_index  output  IDX_W  currently highlighted option
confirm_valid  output  1  one-cycle pulse when an option is confirmed
confirm_index  output  IDX_W  index latched at confirm; stable until the next confirm

Behaviour:
- Reset values: selected_index=DEFAULT_INDEX, confirm_valid=0, confirm_index=0, edge registers=0, repeat counter=0, FSM=IDLE.
- enable low: same register state as reset, but synchronous. Inputs are ignored. rgb is still driven.
- Direction dir: UP when control_up&~control_down; DOWN when control_down&~control_up; otherwise NONE. Both pressed counts as NONE.
- Repeat FSM states:
  - IDLE to DELAY on dir≠NONE. The same cycle issues one move and loads counter=REPEAT_DELAY-1.
  - DELAY: counter decrements. At 0, issue a move, load REPEAT_PERIOD-1 and go to REPEAT.
  - REPEAT: at 0, issue a move and reload.
  - From any state: dir==NONE returns to IDLE. A dir change (UP↔DOWN) is treated as a fresh press: move, then DELAY.
- Move latency: selected_index updates on the clock edge where the move is issued. The new value is visible 1 cycle after the input is first sampled high.
- Move arithmetic, with WRAP=0:
  - UP at index 0 holds.
  - DOWN at NUM_OPTIONS-1 holds.
- Move arithmetic, with WRAP=1:
  - UP at 0 goes to NUM_OPTIONS-1.
  - DOWN at NUM_OPTIONS-1 goes to 0.
  - This must work for non-power-of-two NUM_OPTIONS; never compare against 2^IDX_W-1.
- Confirm:
  - A rising edge of control_select (registered previous value) while enable is high sets confirm_valid=1 for exactly 1 cycle, the cycle after the edge is sampled.
  - confirm_index takes the selected_index value from the sampling cycle.
  - A move issued in the same cycle does not affect the confirmed index.
  - Holding select produces no further pulses.
- rgb (combinational from row/col/selected_index):
  - Inside box k with k==selected_index: 3'b111.
  - Inside the 1-pixel border of any other box: 3'b010.
  - Otherwise: 3'b000.
  - Box k is col in [ITEM_COL0, ITEM_COL0+ITEM_W) and row in [ITEM_ROW0+k*ITEM_H, ITEM_ROW0+(k+1)*ITEM_H).
- Reset mid-hold clears everything asynchronously. After release, a move requires a fresh press evaluation: dir must be re-sampled from IDLE.

Decomposition:
- Package gui_pkg holds:
  - COLOR_* 3-bit constants (BLACK, GREEN, WHITE).
  - The repeat-FSM state enum {IDLE, DELAY, REPEAT}.
- One sub-module is natural: hold_repeat (direction + repeat FSM + counter). Its outputs are a one-cycle move_up/move_down pulse. It is reusable for paddle nudging.
- The index and confirm logic and the pixel decoder stay in menu_selector.

Test Plan:
- Reset, NUM_OPTIONS=3, WRAP=0, DEFAULT_INDEX=0. One-cycle down pulse twice → selected_index 1, then 2. A third down pulse → stays 2.
- WRAP=1, NUM_OPTIONS=3, index 0. Up pulse → 2. Down pulse → 0.
- REPEAT_DELAY=10, REPEAT_PERIOD=4. Hold down for 30 cycles from index 0 with NUM_OPTIONS=8 → moves at cycles 1, 11, 15, 19, 23, 27. Final index 6.
- Up and down both high for 20 cycles → index unchanged, FSM stays IDLE.
- At index 2, raise select and hold 10 cycles → exactly one confirm_valid pulse with confirm_index=2. Drop enable → index returns to DEFAULT_INDEX, no pulse.
- Query (row=ITEM_ROW0+ITEM_H+5, col=ITEM_COL0+5) with index 1 → rgb=3'b111. With index 0 → 3'b000 (interior of a non-selected box). Same query at col=ITEM_COL0 with index 0 → 3'b010 (border).
